// File: rtl/matched_filter_receiver_if.sv
// Sample-stream and decision bus of the matched-filter receiver.
// The master drives channel samples; the slave (the receiver) returns filter output and decisions.
interface matched_filter_receiver_if;
    logic signed [15:0] samp_in;
    logic               samp_valid;
    logic               sym_sync;
    logic signed [15:0] filt_out;
    logic               filt_valid;
    logic               sym_out;
    logic               sym_valid;
    logic               locked;

    modport master (
        output samp_in, samp_valid, sym_sync,
        input  filt_out, filt_valid, sym_out, sym_valid, locked
    );

    modport slave (
        input  samp_in, samp_valid, sym_sync,
        output filt_out, filt_valid, sym_out, sym_valid, locked
    );
endinterface

// File: rtl/matched_filter_receiver.sv
// Matched FIR receiver: 31-tap filter on the shared symmetric pulse, decimation by SPS,
// hard sign decision per symbol. Also carries the shared pulse table (impulse_response).
module impulse_response (
    output logic signed [15:0] out1,  out2,  out3,  out4,  out5,  out6,  out7,  out8,
    output logic signed [15:0] out9,  out10, out11, out12, out13, out14, out15, out16,
    output logic signed [15:0] out17, out18, out19, out20, out21, out22, out23, out24,
    output logic signed [15:0] out25, out26, out27, out28, out29, out30, out31
);
    // Symmetric Q1.15 pulse, peak at out16, zero crossings every 3 samples.
    assign out1  =  16'sd0;
    assign out2  =  16'sd350;
    assign out3  =  16'sd400;
    assign out4  =  16'sd0;
    assign out5  = -16'sd750;
    assign out6  = -16'sd800;
    assign out7  =  16'sd0;
    assign out8  =  16'sd1400;
    assign out9  =  16'sd1500;
    assign out10 =  16'sd0;
    assign out11 = -16'sd2700;
    assign out12 = -16'sd2800;
    assign out13 =  16'sd0;
    assign out14 =  16'sd6800;
    assign out15 =  16'sd13400;
    assign out16 =  16'sd16384;
    assign out17 =  16'sd13400;
    assign out18 =  16'sd6800;
    assign out19 =  16'sd0;
    assign out20 = -16'sd2800;
    assign out21 = -16'sd2700;
    assign out22 =  16'sd0;
    assign out23 =  16'sd1500;
    assign out24 =  16'sd1400;
    assign out25 =  16'sd0;
    assign out26 = -16'sd800;
    assign out27 = -16'sd750;
    assign out28 =  16'sd0;
    assign out29 =  16'sd400;
    assign out30 =  16'sd350;
    assign out31 =  16'sd0;
endmodule

module matched_filter_receiver #(
    parameter int NTAPS = 31,
    parameter int SPS   = 3,
    parameter int PHASE = 0,
    parameter int ACC_W = 37
) (
    input  logic                      clk,
    input  logic                      reset,
    matched_filter_receiver_if.slave  bus
);
    localparam int PH_W   = (SPS > 1) ? $clog2(SPS) : 1;
    localparam int FILL_W = $clog2(NTAPS + 1);
    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(32767);
    localparam logic signed [ACC_W-1:0] SAT_MIN = -ACC_W'(32768);

    typedef enum logic [1:0] {IDLE, FILL, RUN} state_t;

    logic signed [15:0]      coef [NTAPS];
    logic signed [15:0]      tap_reg [NTAPS];
    logic signed [31:0]      prod [NTAPS];
    logic signed [ACC_W-1:0] acc_sum;
    logic signed [ACC_W-1:0] acc_shift;
    logic signed [15:0]      sat_res;

    state_t              state_reg;
    logic [PH_W-1:0]     phase_reg;
    logic [FILL_W-1:0]   fill_reg;
    logic                pend_reg;
    logic                dec_pend_reg;

    logic [PH_W-1:0]     tag_next;
    logic [PH_W-1:0]     phase_next;
    logic [FILL_W-1:0]   fill_next;
    logic                full_next;

    impulse_response u_ir (
        .out1 (coef[0]),  .out2 (coef[1]),  .out3 (coef[2]),  .out4 (coef[3]),
        .out5 (coef[4]),  .out6 (coef[5]),  .out7 (coef[6]),  .out8 (coef[7]),
        .out9 (coef[8]),  .out10(coef[9]),  .out11(coef[10]), .out12(coef[11]),
        .out13(coef[12]), .out14(coef[13]), .out15(coef[14]), .out16(coef[15]),
        .out17(coef[16]), .out18(coef[17]), .out19(coef[18]), .out20(coef[19]),
        .out21(coef[20]), .out22(coef[21]), .out23(coef[22]), .out24(coef[23]),
        .out25(coef[24]), .out26(coef[25]), .out27(coef[26]), .out28(coef[27]),
        .out29(coef[28]), .out30(coef[29]), .out31(coef[30])
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NTAPS; i++) tap_reg[i] <= '0;
        end else if (bus.samp_valid) begin
            tap_reg[0] <= bus.samp_in;
            for (int i = 1; i < NTAPS; i++) tap_reg[i] <= tap_reg[i-1];
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NTAPS; gi++) begin : g_mac
            assign prod[gi] = 32'(tap_reg[gi]) * 32'(coef[gi]);
        end
    endgenerate

    // Full-precision sum; the window is sampled one edge after the accept that completed it.
    always_comb begin
        acc_sum = '0;
        for (int i = 0; i < NTAPS; i++) begin
            acc_sum = acc_sum + {{(ACC_W-32){prod[i][31]}}, prod[i]};
        end
        acc_shift = acc_sum >>> 15;
        if (acc_shift > SAT_MAX)
            sat_res = 16'sh7FFF;
        else if (acc_shift < SAT_MIN)
            sat_res = 16'sh8000;
        else
            sat_res = acc_shift[15:0];
    end

    always_comb begin
        tag_next   = bus.sym_sync ? '0 : phase_reg;
        phase_next = (tag_next == PH_W'(SPS - 1)) ? '0 : tag_next + 1'b1;
        fill_next  = (fill_reg == FILL_W'(NTAPS)) ? fill_reg : fill_reg + 1'b1;
        full_next  = (fill_next == FILL_W'(NTAPS));
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg      <= IDLE;
            phase_reg      <= '0;
            fill_reg       <= '0;
            pend_reg       <= 1'b0;
            dec_pend_reg   <= 1'b0;
            bus.filt_out   <= '0;
            bus.filt_valid <= 1'b0;
            bus.sym_out    <= 1'b0;
            bus.sym_valid  <= 1'b0;
            bus.locked     <= 1'b0;
        end else begin
            pend_reg       <= bus.samp_valid;
            dec_pend_reg   <= bus.samp_valid && (tag_next == PH_W'(PHASE)) && full_next;
            bus.filt_valid <= pend_reg;
            bus.sym_valid  <= pend_reg && dec_pend_reg;
            if (pend_reg)
                bus.filt_out <= sat_res;
            if (pend_reg && dec_pend_reg)
                bus.sym_out <= ~sat_res[15];

            if (bus.samp_valid) begin
                phase_reg <= phase_next;
                fill_reg  <= fill_next;
                case (state_reg)
                    IDLE, FILL: begin
                        if (full_next) begin
                            state_reg  <= RUN;
                            bus.locked <= 1'b1;
                        end else begin
                            state_reg  <= FILL;
                        end
                    end
                    RUN:     state_reg <= RUN;
                    default: state_reg <= IDLE;
                endcase
            end
        end
    end
endmodule
